// File: rtl/dac_spi_pkg.sv
// -----------------------------------------------------------------------------
// dac_spi_pkg
// Shared definitions for the quad 12-bit DAC serial responder:
//   - command codes carried in the frame's command nibble
//   - the broadcast address code
//   - bit positions of the command / address / data fields in the shift register
//   - responder FSM state encoding
//   - frame_len_ok(): accepted frame lengths (short 24-bit or full-length frame)
// -----------------------------------------------------------------------------
package dac_spi_pkg;

    localparam logic [3:0] CMD_WR_IN      = 4'b0000;
    localparam logic [3:0] CMD_UPD        = 4'b0001;
    localparam logic [3:0] CMD_WR_UPD_ALL = 4'b0010;
    localparam logic [3:0] CMD_WR_UPD     = 4'b0011;
    localparam logic [3:0] CMD_PD         = 4'b0100;
    localparam logic [3:0] CMD_NOP        = 4'b1111;

    localparam logic [3:0] ADDR_ALL = 4'b1111;

    // Field positions are the same for 24-bit and 32-bit frames because both
    // end with the same 24 bits in the low end of the shift register.
    localparam int CMD_MSB  = 23;
    localparam int CMD_LSB  = 20;
    localparam int ADDR_MSB = 19;
    localparam int ADDR_LSB = 16;
    localparam int DATA_LSB = 4;

    localparam int SHORT_BITS = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_DECODE = 2'd2
    } state_e;

    function automatic logic frame_len_ok(input int cnt, input int word_bits);
        return (cnt == SHORT_BITS) || (cnt == word_bits);
    endfunction

endpackage

// File: rtl/ltc2624_spi_responder_sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for an asynchronous input followed by a third flop
// used to detect edges of the synchronized level.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   async_in     asynchronous input pin
//   level        synchronized level
//   rise / fall  one-cycle pulses on a synchronized rising / falling edge
// -----------------------------------------------------------------------------
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], async_in};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/ltc2624_spi_responder.sv
// -----------------------------------------------------------------------------
// ltc2624_spi_responder
// Behavioural-accurate, synthesizable responder for the quad 12-bit DAC serial
// interface. Frames arriving on spi_sck/spi_mosi/dac_cs are shifted in,
// decoded on the chip-select rising edge, and applied to four input registers,
// four DAC registers and a power-down mask. spi_sdo echoes the incoming bit
// stream delayed by one full shift register (32 bits).
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   spi_sck        SPI clock (asynchronous, each phase >= 2 clk periods)
//   spi_mosi       serial data in, MSB first
//   dac_cs         chip select, active low
//   dac_clr        clear, active low: zeroes and holds input/DAC registers
//   spi_sdo        serial echo output
//   dac_out        DAC register values, channel 0 in the LSBs, 0 if powered down
//   pd_mask        per-channel power-down flags (1 = powered down)
//   word_valid     one-cycle pulse for every accepted frame
//   cmd_out        command nibble of the last accepted frame
//   addr_out       address nibble of the last accepted frame
//   frame_err      one-cycle pulse for a frame of unsupported length
// -----------------------------------------------------------------------------
module ltc2624_spi_responder
    import dac_spi_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 12,
    parameter int WORD_BITS = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_sck,
    input  logic                     spi_mosi,
    input  logic                     dac_cs,
    input  logic                     dac_clr,
    output logic                     spi_sdo,
    output logic [NUM_CH*DATA_W-1:0] dac_out,
    output logic [NUM_CH-1:0]        pd_mask,
    output logic                     word_valid,
    output logic [3:0]               cmd_out,
    output logic [3:0]               addr_out,
    output logic                     frame_err
);

    localparam int CNT_W = $clog2(WORD_BITS + 1);

    // ---------------- input synchronization ----------------
    logic sck_rise;
    logic sck_level_unused;
    logic sck_fall_unused;
    logic cs_rise;
    logic cs_fall;
    logic cs_level_unused;

    sync_edge u_sck_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (spi_sck),
        .level    (sck_level_unused),
        .rise     (sck_rise),
        .fall     (sck_fall_unused)
    );

    sync_edge u_cs_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (dac_cs),
        .level    (cs_level_unused),
        .rise     (cs_rise),
        .fall     (cs_fall)
    );

    // mosi goes through the same two-flop depth as sck so the sampled bit is
    // aligned with the detected sck rising edge.
    logic [1:0] mosi_sync_q;
    logic [1:0] mosi_sync_d;
    logic [1:0] clr_sync_q;
    logic [1:0] clr_sync_d;
    logic       mosi_s;
    logic       clr_active;

    always_comb begin
        mosi_sync_d = {mosi_sync_q[0], spi_mosi};
        clr_sync_d  = {clr_sync_q[0], dac_clr};
    end

    assign mosi_s     = mosi_sync_q[1];
    assign clr_active = ~clr_sync_q[1];

    // ---------------- state ----------------
    state_e                          state_q,  state_d;
    logic [CNT_W-1:0]                cnt_q,    cnt_d;
    logic [WORD_BITS-1:0]            sr_q,     sr_d;
    logic                            sdo_q,    sdo_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   in_q,     in_d;
    logic [NUM_CH-1:0][DATA_W-1:0]   dac_q,    dac_d;
    logic [NUM_CH-1:0]               pd_q,     pd_d;
    logic                            wv_q,     wv_d;
    logic                            fe_q,     fe_d;
    logic [3:0]                      cmd_q,    cmd_d;
    logic [3:0]                      addr_q,   addr_d;

    // ---------------- frame field decode ----------------
    logic [3:0]        fr_cmd;
    logic [3:0]        fr_addr;
    logic [DATA_W-1:0] fr_data;
    logic [NUM_CH-1:0] sel;
    logic              addr_ok;

    assign fr_cmd  = sr_q[CMD_MSB:CMD_LSB];
    assign fr_addr = sr_q[ADDR_MSB:ADDR_LSB];
    assign fr_data = sr_q[DATA_LSB +: DATA_W];

    always_comb begin
        sel = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sel[ch] = (fr_addr == ADDR_ALL) || (fr_addr == 4'(ch));
        end
        addr_ok = |sel;
    end

    // ---------------- next-state / register update ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        sdo_d   = sdo_q;
        in_d    = in_q;
        dac_d   = dac_q;
        pd_d    = pd_q;
        wv_d    = 1'b0;
        fe_d    = 1'b0;
        cmd_d   = cmd_q;
        addr_d  = addr_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (sck_rise) begin
                    sr_d  = {sr_q[WORD_BITS-2:0], mosi_s};
                    sdo_d = sr_q[WORD_BITS-1];
                    if (cnt_q != CNT_W'(WORD_BITS)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A fresh falling edge means cs glitched high and back: restart.
                if (cs_fall) begin
                    cnt_d = '0;
                end else if (cs_rise) begin
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                state_d = ST_IDLE;
                if (frame_len_ok(int'(cnt_q), WORD_BITS)) begin
                    wv_d   = 1'b1;
                    cmd_d  = fr_cmd;
                    addr_d = fr_addr;
                    // Register effects are suppressed entirely while clear is
                    // active, including the power-down mask.
                    if (addr_ok && !clr_active) begin
                        case (fr_cmd)
                            CMD_WR_IN: begin
                                for (int ch = 0; ch < NUM_CH; ch++) begin
                                    if (sel[ch]) in_d[ch] = fr_data;
                                end
                            end
                            CMD_UPD: begin
                                for (int ch = 0; ch < NUM_CH; ch++) begin
                                    if (sel[ch]) begin
                                        dac_d[ch] = in_q[ch];
                                        pd_d[ch]  = 1'b0;
                                    end
                                end
                            end
                            CMD_WR_UPD_ALL: begin
                                // Every channel loads its (possibly just written)
                                // input register; power-down state is kept.
                                for (int ch = 0; ch < NUM_CH; ch++) begin
                                    if (sel[ch]) begin
                                        in_d[ch]  = fr_data;
                                        dac_d[ch] = fr_data;
                                    end else begin
                                        dac_d[ch] = in_q[ch];
                                    end
                                end
                            end
                            CMD_WR_UPD: begin
                                for (int ch = 0; ch < NUM_CH; ch++) begin
                                    if (sel[ch]) begin
                                        in_d[ch]  = fr_data;
                                        dac_d[ch] = fr_data;
                                        pd_d[ch]  = 1'b0;
                                    end
                                end
                            end
                            CMD_PD: begin
                                for (int ch = 0; ch < NUM_CH; ch++) begin
                                    if (sel[ch]) pd_d[ch] = 1'b1;
                                end
                            end
                            default: begin
                                // CMD_NOP and undefined codes change nothing.
                            end
                        endcase
                    end
                end else begin
                    fe_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clear overrides any update computed above and holds registers at 0.
        if (clr_active) begin
            in_d  = '0;
            dac_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mosi_sync_q <= '0;
            clr_sync_q  <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            sdo_q       <= 1'b0;
            in_q        <= '0;
            dac_q       <= '0;
            pd_q        <= '1;
            wv_q        <= 1'b0;
            fe_q        <= 1'b0;
            cmd_q       <= '0;
            addr_q      <= '0;
        end else begin
            mosi_sync_q <= mosi_sync_d;
            clr_sync_q  <= clr_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            sdo_q       <= sdo_d;
            in_q        <= in_d;
            dac_q       <= dac_d;
            pd_q        <= pd_d;
            wv_q        <= wv_d;
            fe_q        <= fe_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        dac_out = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            dac_out[ch*DATA_W +: DATA_W] = pd_q[ch] ? '0 : dac_q[ch];
        end
    end

    assign spi_sdo    = sdo_q;
    assign pd_mask    = pd_q;
    assign word_valid = wv_q;
    assign frame_err  = fe_q;
    assign cmd_out    = cmd_q;
    assign addr_out   = addr_q;

endmodule

// File: tb/tb_ltc2624_spi_responder.sv
// -----------------------------------------------------------------------------
// Testbench for ltc2624_spi_responder: table of directed frames, hand-written
// multi-cycle sequences, then random frames checked against a register-level
// reference model.
// -----------------------------------------------------------------------------
module tb_ltc2624_spi_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        dac_cs = 1'b1;
    logic        dac_clr = 1'b1;
    logic        spi_sdo;
    logic [47:0] dac_out;
    logic [3:0]  pd_mask;
    logic        word_valid;
    logic [3:0]  cmd_out;
    logic [3:0]  addr_out;
    logic        frame_err;

    ltc2624_spi_responder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .dac_cs     (dac_cs),
        .dac_clr    (dac_clr),
        .spi_sdo    (spi_sdo),
        .dac_out    (dac_out),
        .pd_mask    (pd_mask),
        .word_valid (word_valid),
        .cmd_out    (cmd_out),
        .addr_out   (addr_out),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wv_cnt   = 0;
    int fe_cnt   = 0;

    always @(posedge clk) begin
        if (word_valid) wv_cnt <= wv_cnt + 1;
        if (frame_err)  fe_cnt <= fe_cnt + 1;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [11:0] m_in  [4];
    logic [11:0] m_dac [4];
    bit          m_pd  [4];
    logic [3:0]  m_cmd;
    logic [3:0]  m_addr;

    function automatic void model_reset();
        for (int c = 0; c < 4; c++) begin
            m_in[c] = '0; m_dac[c] = '0; m_pd[c] = 1'b1;
        end
        m_cmd = '0; m_addr = '0;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < 4; c++) begin
            m_in[c] = '0; m_dac[c] = '0;
        end
    endfunction

    // Returns 1 when the frame is accepted. n bits were sent MSB first; the
    // responder keeps the last 32 of them and counts up to 32.
    function automatic bit model_frame(input int n, input logic [39:0] w, input bit clr_now);
        int  cnt;
        int  cmd;
        int  addr;
        int  data;
        bit  hit [4];
        bit  any;
        cnt = (n > 32) ? 32 : n;
        if (cnt != 24 && cnt != 32) return 1'b0;
        cmd  = int'((w >> 20) % 16);
        addr = int'((w >> 16) % 16);
        data = int'((w >> 4) % 4096);
        m_cmd  = 4'(cmd);
        m_addr = 4'(addr);
        if (clr_now) begin
            model_clear();
            return 1'b1;
        end
        any = 1'b0;
        for (int c = 0; c < 4; c++) begin
            hit[c] = (addr == 15) || (addr == c);
            any |= hit[c];
        end
        if (!any) return 1'b1;
        case (cmd)
            0: for (int c = 0; c < 4; c++) if (hit[c]) m_in[c] = 12'(data);
            1: for (int c = 0; c < 4; c++) if (hit[c]) begin m_dac[c] = m_in[c]; m_pd[c] = 1'b0; end
            2: begin
                for (int c = 0; c < 4; c++) if (hit[c]) m_in[c] = 12'(data);
                for (int c = 0; c < 4; c++) m_dac[c] = m_in[c];
            end
            3: for (int c = 0; c < 4; c++) if (hit[c]) begin
                   m_in[c] = 12'(data); m_dac[c] = 12'(data); m_pd[c] = 1'b0;
               end
            4: for (int c = 0; c < 4; c++) if (hit[c]) m_pd[c] = 1'b1;
            default: ;
        endcase
        return 1'b1;
    endfunction

    function automatic logic [47:0] model_dac_out();
        logic [47:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) r[c*12 +: 12] = m_pd[c] ? 12'h000 : m_dac[c];
        return r;
    endfunction

    function automatic logic [3:0] model_pd();
        logic [3:0] r;
        for (int c = 0; c < 4; c++) r[c] = m_pd[c];
        return r;
    endfunction

    // ---------------- SPI driver ----------------
    // clr_mode: 0 none, 1 clear pulse in the middle of the frame,
    //           2 clear asserted together with the cs rising edge.
    task automatic send_frame(input logic [39:0] w, input int n, input int clr_mode,
                              output logic [31:0] cap, output int lat);
        cap = '0;
        lat = -1;
        @(negedge clk);
        dac_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            if (clr_mode == 1 && i == n - 10) dac_clr = 1'b0;
            spi_sck  = 1'b0;
            spi_mosi = w[i];
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
            cap = {cap[30:0], spi_sdo};
            if (clr_mode == 1) dac_clr = 1'b1;
        end
        spi_sck = 1'b0;
        repeat (4) @(negedge clk);
        dac_cs = 1'b1;
        if (clr_mode == 2) dac_clr = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (lat < 0 && (word_valid || frame_err)) lat = k;
            if (k == 8) dac_clr = 1'b1;
        end
    endtask

    // Sends a frame, updates the model, compares everything observable.
    task automatic run_and_check(input string nm, input logic [39:0] w, input int n,
                                 input int clr_mode);
        int          wv0;
        int          fe0;
        int          lat;
        bit          ok;
        logic [31:0] cap;
        wv0 = wv_cnt;
        fe0 = fe_cnt;
        if (clr_mode == 1) model_clear();
        send_frame(w, n, clr_mode, cap, lat);
        ok = model_frame(n, w, clr_mode == 2);
        chk({nm, " dac_out"}, 64'(dac_out), 64'(model_dac_out()));
        chk({nm, " pd_mask"}, 64'(pd_mask), 64'(model_pd()));
        chk({nm, " word_valid pulses"}, 64'(wv_cnt - wv0), ok ? 64'd1 : 64'd0);
        chk({nm, " frame_err pulses"}, 64'(fe_cnt - fe0), ok ? 64'd0 : 64'd1);
        if (ok) begin
            chk({nm, " cmd_out"}, 64'(cmd_out), 64'(m_cmd));
            chk({nm, " addr_out"}, 64'(addr_out), 64'(m_addr));
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          n;
        logic [39:0] w;
        logic [47:0] exp_dac;
        logic [3:0]  exp_pd;
        bit          exp_ok;
        logic [3:0]  exp_cmd;
        logic [3:0]  exp_addr;
    } vec_t;

    vec_t vecs [11];

    initial begin
        logic [31:0] cap;
        int          lat;
        int          wv0;
        int          fe0;
        logic [39:0] w;
        logic [3:0]  cmd;
        logic [3:0]  addr;
        int          r;
        int          n;
        int          nsel [9];

        vecs[0]  = '{32, 40'h00_0030_ABC0, 48'h000_000_000_ABC, 4'b1110, 1'b1, 4'h3, 4'h0};
        vecs[1]  = '{32, 40'h00_0002_1230, 48'h000_000_000_ABC, 4'b1110, 1'b1, 4'h0, 4'h2};
        vecs[2]  = '{32, 40'h00_0012_0000, 48'h000_123_000_ABC, 4'b1010, 1'b1, 4'h1, 4'h2};
        vecs[3]  = '{32, 40'h00_0042_0000, 48'h000_000_000_ABC, 4'b1110, 1'b1, 4'h4, 4'h2};
        vecs[4]  = '{24, 40'h00_003F_8000, 48'h800_800_800_800, 4'b0000, 1'b1, 4'h3, 4'hF};
        vecs[5]  = '{23, 40'h00_0012_3456, 48'h800_800_800_800, 4'b0000, 1'b0, 4'h3, 4'hF};
        vecs[6]  = '{25, 40'h00_01A5_5A5A, 48'h800_800_800_800, 4'b0000, 1'b0, 4'h3, 4'hF};
        vecs[7]  = '{31, 40'h00_7ABC_DEF0, 48'h800_800_800_800, 4'b0000, 1'b0, 4'h3, 4'hF};
        vecs[8]  = '{32, 40'h00_0035_5550, 48'h800_800_800_800, 4'b0000, 1'b1, 4'h3, 4'h5};
        vecs[9]  = '{32, 40'h00_0070_0770, 48'h800_800_800_800, 4'b0000, 1'b1, 4'h7, 4'h0};
        vecs[10] = '{32, 40'h00_00FF_0120, 48'h800_800_800_800, 4'b0000, 1'b1, 4'hF, 4'hF};

        // ---------------- reset ----------------
        #2 rst_n = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        model_reset();
        chk("reset dac_out", 64'(dac_out), 64'h0);
        chk("reset pd_mask", 64'(pd_mask), 64'hF);
        chk("reset word_valid", 64'(word_valid), 64'h0);
        chk("reset frame_err", 64'(frame_err), 64'h0);
        chk("reset cmd_out", 64'(cmd_out), 64'h0);
        chk("reset addr_out", 64'(addr_out), 64'h0);
        chk("reset spi_sdo", 64'(spi_sdo), 64'h0);

        // ---------------- table-driven frames ----------------
        for (int v = 0; v < 11; v++) begin
            wv0 = wv_cnt;
            fe0 = fe_cnt;
            send_frame(vecs[v].w, vecs[v].n, 0, cap, lat);
            void'(model_frame(vecs[v].n, vecs[v].w, 1'b0));
            chk($sformatf("vec%0d dac_out", v), 64'(dac_out), 64'(vecs[v].exp_dac));
            chk($sformatf("vec%0d pd_mask", v), 64'(pd_mask), 64'(vecs[v].exp_pd));
            chk($sformatf("vec%0d word_valid", v), 64'(wv_cnt - wv0), vecs[v].exp_ok ? 64'd1 : 64'd0);
            chk($sformatf("vec%0d frame_err", v), 64'(fe_cnt - fe0), vecs[v].exp_ok ? 64'd0 : 64'd1);
            chk($sformatf("vec%0d latency", v), 64'(lat), 64'd4);
            chk($sformatf("vec%0d cmd_out", v), 64'(cmd_out), 64'(vecs[v].exp_cmd));
            chk($sformatf("vec%0d addr_out", v), 64'(addr_out), 64'(vecs[v].exp_addr));
        end

        // ---------------- back-to-back frames: sdo echo ----------------
        send_frame(40'h00_0031_2340, 32, 0, cap, lat);
        void'(model_frame(32, 40'h00_0031_2340, 1'b0));
        w = {8'h00, 32'($urandom)};
        send_frame(w, 32, 0, cap, lat);
        void'(model_frame(32, w, 1'b0));
        chk("sdo echo of W1", 64'(cap), 64'h0031_2340);
        chk("after W2 dac_out", 64'(dac_out), 64'(model_dac_out()));

        // ---------------- clear mid-frame ----------------
        run_and_check("setup pd3", 40'h00_0043_0000, 32, 0);
        run_and_check("clr mid", 40'h00_00F0_0000, 32, 1);
        chk("clr mid all zero", 64'(dac_out), 64'h0);
        run_and_check("refill ch0", 40'h00_0030_1110, 32, 0);

        // ---------------- clear coincident with decode ----------------
        wv0 = wv_cnt;
        run_and_check("clr coincident", 40'h00_004F_0000, 32, 2);
        chk("clr coincident zero", 64'(dac_out), 64'h0);
        chk("clr coincident pd kept", 64'(pd_mask), 64'b1000);
        chk("clr coincident pulse", 64'(wv_cnt - wv0), 64'd1);
        run_and_check("upd after clear", 40'h00_001F_0000, 32, 0);
        chk("inputs cleared", 64'(dac_out), 64'h0);

        // ---------------- reset mid-frame ----------------
        @(negedge clk);
        dac_cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            spi_sck = 1'b0; spi_mosi = i[0];
            repeat (4) @(negedge clk);
            spi_sck = 1'b1;
            repeat (4) @(negedge clk);
        end
        rst_n = 1'b0;
        spi_sck = 1'b0;
        dac_cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset dac_out", 64'(dac_out), 64'h0);
        chk("midreset pd_mask", 64'(pd_mask), 64'hF);
        chk("midreset cmd_out", 64'(cmd_out), 64'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midreset no pulse", 64'(word_valid | frame_err), 64'h0);
        model_reset();
        run_and_check("post-reset frame", 40'h00_0031_5A50, 32, 0);
        chk("post-reset ch1", 64'(dac_out), 64'h0000_005A_5000);
        chk("post-reset pd", 64'(pd_mask), 64'b1101);

        // ---------------- random frames ----------------
        nsel = '{24, 32, 32, 32, 24, 23, 25, 31, 33};
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: cmd = 4'h0;
                1: cmd = 4'h1;
                2: cmd = 4'h2;
                3: cmd = 4'h3;
                4: cmd = 4'h4;
                5: cmd = 4'hF;
                default: cmd = 4'($urandom_range(0, 15));
            endcase
            r = $urandom_range(0, 9);
            if (r < 6)      addr = 4'(r % 4);
            else if (r < 8) addr = 4'hF;
            else            addr = 4'($urandom_range(0, 15));
            w = {8'($urandom), 8'($urandom), cmd, addr, 12'($urandom), 4'($urandom)};
            n = nsel[$urandom_range(0, 8)];
            run_and_check($sformatf("rand%0d", t), w, n, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule
